// File: rtl/clock_pkg.sv
// Shared types and constants for the MM:SS timekeeping core.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        ADJUST = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    localparam int SEC_MAX         = 59;
    localparam int MAX_MIN_DEFAULT = 59;

    function automatic logic bcd2_is(input bcd2_t v, input int max);
        return (v.tens == bcd_t'(max / 10)) && (v.ones == bcd_t'(max % 10));
    endfunction

    // Two-digit BCD increment that wraps max -> 00.
    function automatic bcd2_t bcd2_inc(input bcd2_t v, input int max);
        bcd2_t r;
        if (bcd2_is(v, max)) begin
            r = '0;
        end else if (v.ones == 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, tick_fast-sampled streak
// debounce and a one-clk pulse on each accepted press.
module button_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick_fast,
    output logic press
);

    localparam int CW = $clog2(DEB_SAMPLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] streak;
    logic          level;
    logic          sample;
    logic          accept;

    assign sample = sync[1];
    assign accept = tick_fast && (sample != level) && (streak == CW'(DEB_SAMPLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            streak <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            // Pulse only when a new high level is accepted; release is silent.
            press <= accept && sample;
            if (tick_fast) begin
                if (sample == level || accept) begin
                    streak <= '0;
                end else begin
                    streak <= streak + 1'b1;
                end
                if (accept) begin
                    level <= sample;
                end
            end
        end
    end

endmodule

// File: rtl/clock_counter_ctrl.sv
// MM:SS BCD timekeeping core with RUN/PAUSE/ADJUST control, debounced
// pause/clear buttons and blink requests for the display scanner.
module clock_counter_ctrl
    import clock_pkg::*;
#(
    parameter int MAX_MIN     = MAX_MIN_DEFAULT,
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic tick_fast,
    input  logic tick_blink,
    input  logic btn_pause,
    input  logic btn_clr,
    input  logic sw_adj,
    input  logic sw_sel,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic paused,
    output logic blink_min,
    output logic blink_sec
);

    logic   press_pause, press_clr;
    logic [1:0] adj_sync, sel_sync;
    logic   adj_s, sel_s;
    state_t state, state_next, prev, prev_next;
    bcd2_t  cnt_min, cnt_sec, min_next, sec_next;
    logic   phase, phase_next;

    button_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_pause (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_pause),
        .tick_fast (tick_fast),
        .press     (press_pause)
    );

    button_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_clr (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_clr),
        .tick_fast (tick_fast),
        .press     (press_clr)
    );

    assign adj_s = adj_sync[1];
    assign sel_s = sel_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            adj_sync <= '0;
            sel_sync <= '0;
        end else begin
            adj_sync <= {adj_sync[0], sw_adj};
            sel_sync <= {sel_sync[0], sw_sel};
        end
    end

    always_comb begin
        state_next = state;
        prev_next  = prev;
        if (adj_s) begin
            state_next = ADJUST;
            if (state != ADJUST) prev_next = state;
        end else begin
            case (state)
                RUN:     if (press_pause) state_next = PAUSE;
                PAUSE:   if (press_pause) state_next = RUN;
                ADJUST:  state_next = prev;
                default: state_next = RUN;
            endcase
        end
    end

    // Counting decisions use the current state, so a tick coinciding with a
    // state change is applied under the state it arrived in.
    always_comb begin
        min_next = cnt_min;
        sec_next = cnt_sec;
        if (press_clr) begin
            min_next = '0;
            sec_next = '0;
        end else if (state == RUN && tick_1hz) begin
            sec_next = bcd2_inc(cnt_sec, SEC_MAX);
            if (bcd2_is(cnt_sec, SEC_MAX)) min_next = bcd2_inc(cnt_min, MAX_MIN);
        end else if (state == ADJUST && tick_2hz) begin
            if (sel_s) sec_next = bcd2_inc(cnt_sec, SEC_MAX);
            else       min_next = bcd2_inc(cnt_min, MAX_MIN);
        end
    end

    assign phase_next = (state == ADJUST) ? (phase ^ tick_blink) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            prev      <= RUN;
            cnt_min   <= '0;
            cnt_sec   <= '0;
            phase     <= 1'b0;
            paused    <= 1'b0;
            blink_min <= 1'b0;
            blink_sec <= 1'b0;
        end else begin
            state     <= state_next;
            prev      <= prev_next;
            cnt_min   <= min_next;
            cnt_sec   <= sec_next;
            phase     <= phase_next;
            paused    <= (state_next != RUN);
            blink_min <= (state_next == ADJUST) && !sel_s && phase_next;
            blink_sec <= (state_next == ADJUST) &&  sel_s && phase_next;
        end
    end

    assign min_tens = cnt_min.tens;
    assign min_ones = cnt_min.ones;
    assign sec_tens = cnt_sec.tens;
    assign sec_ones = cnt_sec.ones;

endmodule

// File: doc/clock_counter_ctrl.md
Name: clock_counter_ctrl

Overview:
Timekeeping core that consumes the periodic enable ticks from the clock divider: tick_1hz, tick_2hz, tick_fast and tick_blink. It holds an MM:SS count in BCD and debounces the pause and clear buttons. It runs a RUN/PAUSE/ADJUST state machine and drives blink-request flags for the downstream 7-segment scanner. It runs entirely on clk; the ticks are single-cycle enables and are never used as clocks.

Parameters:
MAX_MIN, 59, upper minute value; minutes wrap MAX_MIN -> 00; legal range 1..99.
DEB_SAMPLES, 3, consecutive equal tick_fast samples required to accept a new button level; legal range 2..15.

Ports:
clk  in  1  system clock
rst  in  1  reset
tick_1hz  in  1  one-cycle enable, 1 Hz
tick_2hz  in  1  one-cycle enable, 2 Hz
tick_fast  in  1  one-cycle enable, ~200 Hz; debounce sample strobe
tick_blink  in  1  one-cycle enable; toggles blink phase
btn_pause  in  1  raw asynchronous pushbutton; press toggles RUN/PAUSE
btn_clr  in  1  raw asynchronous pushbutton; press clears count
sw_adj  in  1  raw slide switch; 1 = adjust mode
sw_sel  in  1  raw slide switch; 0 = minutes, 1 = seconds (adjust target)
min_tens  out  4  BCD
min_ones  out  4  BCD
sec_tens  out  4  BCD, 0..5
sec_ones  out  4  BCD
paused  out  1  1 when state != RUN
blink_min  out  1  1 = blank the minute digits this phase
blink_sec  out  1  1 = blank the second digits this phase

Behaviour:
- Reset: rst is synchronous and active-high on clk. During reset, all digits = 0, state = RUN, paused = 0, blink_min = blink_sec = 0, blink phase = 0. All synchronizer flops, debounce counters and debounced levels are cleared to 0.
- Input conditioning:
  - All four raw inputs pass through a 2-flop synchronizer.
  - Buttons are sampled only on tick_fast. A new level is accepted after DEB_SAMPLES consecutive samples that differ from the current debounced level. Any sample equal to the current level resets the streak count.
  - A rising edge of the debounced level gives a one-clk pulse: press_pause or press_clr. There is no pulse on release.
  - Switches are synchronized only, not debounced.
- State machine:
  - The machine has three states: RUN, PAUSE and ADJUST. A prev register records RUN or PAUSE.
  - Any state with adj_s = 1 goes to ADJUST; this has top priority. On entry, prev is set to the state being left.
  - ADJUST with adj_s = 0 returns to prev.
  - RUN with press_pause goes to PAUSE. PAUSE with press_pause goes to RUN. press_pause is ignored in ADJUST.
- Counting:
  - RUN: each tick_1hz increments seconds. Seconds go 59 -> 00 and carry +1 into minutes. Minutes at MAX_MIN wrap to 00. Each digit is BCD: ones 9 -> 0 carries into tens.
  - PAUSE: the count holds.
  - ADJUST: tick_1hz is ignored. Each tick_2hz increments only the selected field (sel_s), with no carry. Seconds wrap 59 -> 00; minutes wrap MAX_MIN -> 00.
- Clear: press_clr sets all digits to 0 in any state and does not change the state. If press_clr and a count tick occur in the same cycle, the clear wins.
- Simultaneous events:
  - press_pause together with tick_1hz in RUN: the increment is applied that cycle, and the state is PAUSE on the next cycle.
  - adj_s rising together with tick_1hz: the increment is still applied, because the state is RUN in that cycle.
- Blink:
  - The phase toggles on each tick_blink and is forced to 0 outside ADJUST.
  - blink_min = (ADJUST && !sel_s && phase). blink_sec = (ADJUST && sel_s && phase).
- Latency and outputs:
  - All outputs are registered. Digits change on the clk edge after the tick cycle.
  - Button latency = 2 clk (sync) + DEB_SAMPLES tick_fast periods + 1 clk (edge detect).
- Invariant: digits are always valid BCD; sec_tens <= 5; minutes <= MAX_MIN.

Decomposition:
- Shared package clock_pkg holds:
  - state enum {RUN, PAUSE, ADJUST};
  - bcd_t (4-bit);
  - constants SEC_MAX = 59 and default MAX_MIN.
- One sub-module, button_debounce. It contains the synchronizer, the tick_fast-sampled streak counter and the rising-edge pulse output. It has parameter DEB_SAMPLES and is instanced twice (pause, clear).
- Switch synchronizers are inline.

Test Plan:
- Bench drives the ticks directly (tick_fast every 10 clk). After rst, issue 61 tick_1hz -> 01:01, paused = 0.
- Preload to 59:59 via adjust, then RUN; one tick_1hz -> 00:00. With MAX_MIN = 9, 09:59 + 1 s -> 00:00.
- Bounce btn_pause, toggling every 2 clk for 40 clk, then hold 1 -> exactly one press_pause; paused = 1. During PAUSE, 5 tick_1hz leave the count unchanged. A second clean press -> RUN.
- Assert press_clr on the same cycle as tick_1hz at 12:34 -> 00:00 on the next clk; state unchanged.
- sw_adj = 1, sw_sel = 1 at 00:58: 3 tick_2hz -> 00:01 (no carry into minutes). 4 tick_blink -> blink_sec toggles 4 times, blink_min stays 0. sw_adj = 0 -> returns to the pre-adjust state.
- Assert rst mid-ADJUST with a debounce in progress -> next clk: 00:00, RUN, all blink flags 0. A button held through reset needs a full DEB_SAMPLES streak before it generates a pulse.
